// File: rtl/decode_pkg.sv
// decode_pkg: opcode values, ALU op encodings and the decoded control bundle
package decode_pkg;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SLL  = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLL = 2'b10;
  localparam logic [1:0] ALU_SRL = 2'b11;
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl: combinational opcode to control bundle and source-register use mask
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic [OP_W-1:0] op,
  output ctrl_t           ctrl,
  output logic            uses_rs1,
  output logic            uses_rs2
);
  logic [31:0] opx;
  logic [2:0]  c;
  logic        ill;
  // widen first so the "above 7" test stays meaningful for any OP_W
  assign opx = 32'(op);
  assign ill = (opx >> 3) != 32'd0;
  assign c   = opx[2:0];
  always_comb begin
    ctrl            = '0;
    ctrl.illegal    = ill;
    ctrl.reg_write  = !ill && (c == OP_ADD || c == OP_ADDI || c == OP_LW ||
                               c == OP_SLL || c == OP_SRL || c == OP_SUB);
    ctrl.alu_src    = !ill && (c == OP_ADDI || c == OP_LW || c == OP_SW);
    ctrl.mem_write  = !ill && c == OP_SW;
    ctrl.mem_read   = !ill && c == OP_LW;
    ctrl.mem_to_reg = !ill && c == OP_LW;
    ctrl.alu_op     = ill ? ALU_ADD :
                      c == OP_SUB ? ALU_SUB :
                      c == OP_SLL ? ALU_SLL :
                      c == OP_SRL ? ALU_SRL : ALU_ADD;
    uses_rs1        = !ill && c != OP_NOP;
    uses_rs2        = !ill && (c == OP_ADD || c == OP_SUB || c == OP_SLL ||
                               c == OP_SRL || c == OP_SW);
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage with IF/EX handshakes, load-use bubble, flush and ID/EX register.
// Define DECODE_STALL_CNT_EN to add the saturating stall_count output.
module decode_stage
  import decode_pkg::*;
#(
  parameter  int OP_W   = 3,
  parameter  int RA_W   = 5,
  parameter  int IMM_W  = 12,
  parameter  int DATA_W = 32,
  localparam int INST_W = OP_W + 2 * RA_W + IMM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [INST_W-1:0] if_inst,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic              ex_reg_write,
  output logic              ex_alu_src,
  output logic              ex_mem_write,
  output logic              ex_mem_read,
  output logic              ex_mem_to_reg,
  output logic [1:0]        ex_alu_op,
  output logic [RA_W-1:0]   ex_rd,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_illegal,
  output logic              hazard_stall
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);
  logic [OP_W-1:0]  op;
  logic [RA_W-1:0]  rd, rs1, rs2;
  logic [IMM_W-1:0] imm;
  ctrl_t            ctrl, ctrl_w, ex_ctrl;
  logic             uses_rs1, uses_rs2, load, take;
  assign {op, rd, rs1, imm} = if_inst;
  decode_ctrl #(.OP_W(OP_W)) u_ctrl (
    .op      (op),
    .ctrl    (ctrl),
    .uses_rs1(uses_rs1),
    .uses_rs2(uses_rs2)
  );
  // stores carry their data register in the rd field
  assign rs2 = ctrl.mem_write ? rd : imm[RA_W-1:0];
  always_comb begin
    ctrl_w           = ctrl;
    ctrl_w.reg_write = ctrl.reg_write && rd != '0;
  end
  assign load         = !ex_valid || ex_ready;
  assign hazard_stall = if_valid && ex_valid && ex_mem_read && ex_rd != '0 &&
                        ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));
  assign if_ready     = load && (!hazard_stall || flush);
  assign take         = if_valid && !hazard_stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rd    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_imm   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load) begin
      ex_valid <= take;
      if (take) begin
        ex_ctrl <= ctrl_w;
        ex_rd   <= rd;
        ex_rs1  <= rs1;
        ex_rs2  <= rs2;
        ex_imm  <= DATA_W'($signed(imm));
      end
    end
  end
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_alu_op     = ex_ctrl.alu_op;
  assign ex_illegal    = ex_ctrl.illegal;
`ifdef DECODE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count <= '0;
    else if (hazard_stall && load && !flush && stall_count != '1) stall_count <= stall_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table vectors, hand sequences and random stimulus against a spec-level model
module tb_decode_stage;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, if_valid = 1'b0, ex_ready = 1'b1;
  logic [24:0] if_inst = '0;
  logic        if_ready, ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read;
  logic        ex_mem_to_reg, ex_illegal, hazard_stall;
  logic [1:0]  ex_alu_op;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [31:0] ex_imm;
  logic        flush4 = 1'b0, if_valid4 = 1'b0, ex_ready4 = 1'b1;
  logic [25:0] if_inst4 = '0;
  logic        if_ready4, ex_valid4, ex_reg_write4, ex_alu_src4, ex_mem_write4, ex_mem_read4;
  logic        ex_mem_to_reg4, ex_illegal4, hazard_stall4;
  logic [1:0]  ex_alu_op4;
  logic [4:0]  ex_rd4, ex_rs14, ex_rs24;
  logic [31:0] ex_imm4;
`ifdef DECODE_STALL_CNT_EN
  logic [31:0] stall_count, stall_count4;
`endif
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_reg_write(ex_reg_write),
    .ex_alu_src(ex_alu_src), .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_illegal(ex_illegal), .hazard_stall(hazard_stall)
`ifdef DECODE_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  decode_stage #(.OP_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4), .if_valid(if_valid4), .if_ready(if_ready4),
    .if_inst(if_inst4), .ex_valid(ex_valid4), .ex_ready(ex_ready4), .ex_reg_write(ex_reg_write4),
    .ex_alu_src(ex_alu_src4), .ex_mem_write(ex_mem_write4), .ex_mem_read(ex_mem_read4),
    .ex_mem_to_reg(ex_mem_to_reg4), .ex_alu_op(ex_alu_op4), .ex_rd(ex_rd4), .ex_rs1(ex_rs14),
    .ex_rs2(ex_rs24), .ex_imm(ex_imm4), .ex_illegal(ex_illegal4), .hazard_stall(hazard_stall4)
`ifdef DECODE_STALL_CNT_EN
    , .stall_count(stall_count4)
`endif
  );

  typedef struct packed {
    logic v, rw, as, mw, mr, m2r;
    logic [1:0] alu;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;
  } exp_t;

  typedef struct {
    int op, rd, rs1, imm;
    logic rw, as, mw, mr;
    logic [1:0] alu;
    logic [4:0] rs2;
    logic [31:0] ximm;
  } vec_t;

  exp_t        m;
  logic        m_v = 1'b0;
  logic [31:0] m_cnt = '0;
  logic        s_haz, s_rdy;
  vec_t        vt[9];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [24:0] mk(input int op, input int rd, input int rs1, input int imm);
    return {op[2:0], rd[4:0], rs1[4:0], imm[11:0]};
  endfunction

  // which sources an opcode reads: {rs2, rs1}
  function automatic logic [1:0] reads(input int op);
    return op == 7 ? 2'b00 : (op == 1 || op == 3) ? 2'b01 : 2'b11;
  endfunction

  function automatic exp_t dec(input logic [24:0] i);
    exp_t e;
    int op, imm;
    logic [4:0] rd;
    op = int'(i[24:22]);
    rd = i[21:17];
    imm = int'(i[11:0]);
    e = '0;
    e.v = 1'b1;
    e.rd = rd;
    e.rs1 = i[16:12];
    e.rs2 = op == 2 ? rd : 5'(imm % 32);
    e.imm = imm >= 2048 ? 32'(imm - 4096) : 32'(imm);
    case (op)
      0: e.rw = 1'b1;
      1: begin e.rw = 1'b1; e.as = 1'b1; end
      2: begin e.as = 1'b1; e.mw = 1'b1; end
      3: begin e.rw = 1'b1; e.as = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; end
      4: begin e.rw = 1'b1; e.alu = 2'b10; end
      5: begin e.rw = 1'b1; e.alu = 2'b11; end
      6: begin e.rw = 1'b1; e.alu = 2'b01; end
      default: ;
    endcase
    if (rd == 0) e.rw = 1'b0;
    return e;
  endfunction

  task automatic check_regs();
    chk("ex_valid", ex_valid, m_v);
    if (m_v) begin
      chk("reg_write", ex_reg_write, m.rw);
      chk("alu_src", ex_alu_src, m.as);
      chk("mem_write", ex_mem_write, m.mw);
      chk("mem_read", ex_mem_read, m.mr);
      chk("mem_to_reg", ex_mem_to_reg, m.m2r);
      chk("alu_op", ex_alu_op, m.alu);
      if (!m.mw) chk("ex_rd", ex_rd, m.rd);
      chk("ex_rs1", ex_rs1, m.rs1);
      chk("ex_rs2", ex_rs2, m.rs2);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_illegal", ex_illegal, 0);
    end
`ifdef DECODE_STALL_CNT_EN
    chk("stall_count", stall_count, m_cnt);
`endif
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic step(input logic v, input logic [24:0] inst, input logic er, input logic fl);
    exp_t d;
    logic [1:0] r;
    logic ld, mh, mr;
    if_valid = v;
    if_inst = inst;
    ex_ready = er;
    flush = fl;
    #1;
    d = dec(inst);
    r = reads(int'(inst[24:22]));
    ld = !m_v || er;
    mh = v && m_v && m.mr && m.rd != 0 && ((r[0] && d.rs1 == m.rd) || (r[1] && d.rs2 == m.rd));
    mr = ld && (!mh || fl);
    s_haz = hazard_stall;
    s_rdy = if_ready;
    chk("if_ready", if_ready, mr);
    chk("hazard_stall", hazard_stall, mh);
    @(posedge clk);
    if (mh && ld && !fl && m_cnt != '1) m_cnt++;
    if (fl) m_v = 1'b0;
    else if (ld && mh) m_v = 1'b0;
    else if (ld && v) begin m = d; m_v = 1'b1; end
    else if (ld) m_v = 1'b0;
    #1 check_regs();
    @(negedge clk);
  endtask

  task automatic reset_mid();
    #2 rst_n = 1'b0;
    if_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_reg_write", ex_reg_write, 0);
    chk("rst_mem_read", ex_mem_read, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_ex_imm", ex_imm, 0);
    chk("rst_if_ready", if_ready, 1);
    m_v = 1'b0;
    m = '0;
    m_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m = '0;
    vt[0] = '{0, 3, 1, 2,      1, 0, 0, 0, 2'b00, 5'd2,  32'h2};
    vt[1] = '{1, 4, 0, 'hFFF,  1, 1, 0, 0, 2'b00, 5'd31, 32'hFFFF_FFFF};
    vt[2] = '{0, 0, 1, 2,      0, 0, 0, 0, 2'b00, 5'd2,  32'h2};
    vt[3] = '{2, 7, 2, 'h805,  0, 1, 1, 0, 2'b00, 5'd7,  32'hFFFF_F805};
    vt[4] = '{3, 5, 1, 4,      1, 1, 0, 1, 2'b00, 5'd4,  32'h4};
    vt[5] = '{4, 1, 1, 3,      1, 0, 0, 0, 2'b10, 5'd3,  32'h3};
    vt[6] = '{5, 2, 3, 'h7E1,  1, 0, 0, 0, 2'b11, 5'd1,  32'h7E1};
    vt[7] = '{6, 9, 8, 'hA,    1, 0, 0, 0, 2'b01, 5'd10, 32'hA};
    vt[8] = '{7, 9, 8, 'h800,  0, 0, 0, 0, 2'b00, 5'd0,  32'hFFFF_F800};
    #1;
    chk("init_ex_valid", ex_valid, 0);
    chk("init_if_ready", if_ready, 1);
    chk("init_ex_rd", ex_rd, 0);
    chk("init_ex_imm", ex_imm, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, mk(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].imm), 1'b1, 1'b0);
      chk("vec_valid", ex_valid, 1);
      chk("vec_reg_write", ex_reg_write, vt[i].rw);
      chk("vec_alu_src", ex_alu_src, vt[i].as);
      chk("vec_mem_write", ex_mem_write, vt[i].mw);
      chk("vec_mem_read", ex_mem_read, vt[i].mr);
      chk("vec_mem_to_reg", ex_mem_to_reg, vt[i].mr);
      chk("vec_alu_op", ex_alu_op, vt[i].alu);
      if (vt[i].op != 2) chk("vec_rd", ex_rd, vt[i].rd);
      chk("vec_rs1", ex_rs1, vt[i].rs1);
      chk("vec_rs2", ex_rs2, vt[i].rs2);
      chk("vec_imm", ex_imm, vt[i].ximm);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    // load-use: one bubble, then the consumer issues
    step(1'b1, mk(3, 5, 1, 0), 1'b1, 1'b0);
    step(1'b1, mk(0, 6, 5, 1), 1'b1, 1'b0);
    chk("lu_stall", s_haz, 1);
    chk("lu_if_ready", s_rdy, 0);
    chk("lu_bubble", ex_valid, 0);
    step(1'b1, mk(0, 6, 5, 1), 1'b1, 1'b0);
    chk("lu_no_stall", s_haz, 0);
    chk("lu_issue_valid", ex_valid, 1);
    chk("lu_issue_rd", ex_rd, 6);
    chk("lu_issue_rs1", ex_rs1, 5);
`ifdef DECODE_STALL_CNT_EN
    chk("lu_count", stall_count, 1);
`endif
    step(1'b1, mk(3, 0, 1, 0), 1'b1, 1'b0);
    step(1'b1, mk(0, 6, 0, 1), 1'b1, 1'b0);
    chk("lw_r0_no_stall", s_haz, 0);
    chk("lw_r0_issue", ex_valid, 1);
    // backpressure from EX
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, mk(0, 3, 1, 2), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, mk(1, 9, 2, 5), 1'b0, 1'b0);
      chk("bp_if_ready", s_rdy, 0);
      chk("bp_hold_valid", ex_valid, 1);
      chk("bp_hold_rd", ex_rd, 3);
      chk("bp_hold_imm", ex_imm, 2);
    end
    step(1'b1, mk(1, 9, 2, 5), 1'b1, 1'b0);
    chk("bp_release_rdy", s_rdy, 1);
    chk("bp_release_rd", ex_rd, 9);
    // flush drops both ID/EX and the offer
    step(1'b1, mk(0, 7, 1, 2), 1'b1, 1'b1);
    chk("fl_if_ready", s_rdy, 1);
    chk("fl_valid", ex_valid, 0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("fl_dropped", ex_valid, 0);
    step(1'b1, mk(3, 5, 1, 0), 1'b1, 1'b0);
    step(1'b1, mk(0, 6, 5, 1), 1'b1, 1'b1);
    chk("fl_haz_stall", s_haz, 1);
    chk("fl_haz_rdy", s_rdy, 1);
    chk("fl_haz_valid", ex_valid, 0);
`ifdef DECODE_STALL_CNT_EN
    chk("fl_haz_count", stall_count, 1);
`endif
    // wide-opcode instance: opcode 9 is illegal but still delivered
    if_valid4 = 1'b1;
    if_inst4 = {4'd9, 5'd3, 5'd1, 12'h002};
    #1;
    chk("w_if_ready", if_ready4, 1);
    chk("w_hazard", hazard_stall4, 0);
    @(posedge clk);
    #1;
    chk("w_valid", ex_valid4, 1);
    chk("w_illegal", ex_illegal4, 1);
    chk("w_reg_write", ex_reg_write4, 0);
    chk("w_alu_src", ex_alu_src4, 0);
    chk("w_mem_write", ex_mem_write4, 0);
    chk("w_mem_read", ex_mem_read4, 0);
    chk("w_mem_to_reg", ex_mem_to_reg4, 0);
    chk("w_alu_op", ex_alu_op4, 0);
    chk("w_rd", ex_rd4, 3);
    chk("w_rs1", ex_rs14, 1);
    chk("w_rs2", ex_rs24, 2);
    chk("w_imm", ex_imm4, 2);
`ifdef DECODE_STALL_CNT_EN
    chk("w_count", stall_count4, 0);
`endif
    @(negedge clk);
    if_inst4 = {4'd3, 5'd4, 5'd1, 12'h010};
    @(posedge clk);
    #1;
    chk("w_lw_illegal", ex_illegal4, 0);
    chk("w_lw_mem_read", ex_mem_read4, 1);
    @(negedge clk);
    if_valid4 = 1'b0;
    // asynchronous reset mid-stream
    step(1'b1, mk(0, 3, 1, 2), 1'b0, 1'b0);
    reset_mid();
    for (int i = 0; i < 400; i++) begin
      int op, rd, rs1, imm;
      op = $urandom_range(0, 7);
      rd = $urandom_range(0, 3);
      rs1 = $urandom_range(0, 3);
      imm = ($urandom_range(0, 127) << 5) | $urandom_range(0, 3);
      step($urandom_range(0, 9) < 8, mk(op, rd, rs1, imm), $urandom_range(0, 3) != 0,
           $urandom_range(0, 11) == 0);
      if (i == 200) reset_mid();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised successor to the single-cycle control decoder; first real sequential block of the ID stage.
- Decodes the full instruction word (opcode, register fields, sign-extended immediate) into the ID/EX pipeline register.
- Provides valid/ready handshakes toward IF and EX, detects load-use hazards, inserts one-cycle bubbles, and supports flush.

Parameters:
OP_W, 3, opcode width (>=3); opcode values >7 are illegal
RA_W, 5, register-address width
IMM_W, 12, immediate width (>=RA_W)
DATA_W, 32, datapath width (>=IMM_W); width of ex_imm
INST_W, OP_W+2*RA_W+IMM_W, localparam, not overridable

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard ID/EX contents and current IF offer
if_valid  in  1  IF offers instruction
if_ready  out  1  ID accepts instruction this cycle
if_inst  in  INST_W  {opcode, rd, rs1, imm}, MSB first
ex_valid  out  1  ID/EX register holds an instruction
ex_ready  in  1  EX consumes ID/EX this cycle
ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_mem_to_reg  out  1 each  control bits
ex_alu_op  out  2  00 ADD, 01 SUB, 10 SLL, 11 SRL
ex_rd, ex_rs1, ex_rs2  out  RA_W each  register addresses
ex_imm  out  DATA_W  sign-extended immediate
ex_illegal  out  1  instruction had an undefined opcode
hazard_stall  out  1  combinational; load-use stall this cycle

Behaviour:
- Opcode map: 0 ADD, 1 ADDI, 2 SW, 3 LW, 4 SLL, 5 SRL, 6 SUB, 7 NOP; any other value is illegal.
- Field decode:
  - rs2 = imm[RA_W-1:0], except SW, where rs2 = rd field (store data) and rd is unused.
  - Immediate is sign-extended from IMM_W to DATA_W.
- Controls:
  - reg_write = 1 for ADD/ADDI/LW/SLL/SRL/SUB, forced to 0 when rd == 0.
  - alu_src = 1 for ADDI/LW/SW.
  - mem_write = SW.
  - mem_read = mem_to_reg = LW.
  - alu_op: SUB = 01, SLL = 10, SRL = 11, all others 00.
- NOP and illegal opcodes: all write/mem controls are 0. Illegal additionally sets ex_illegal = 1 and is still delivered with ex_valid = 1.
- Sources read:
  - ADD/SUB/SLL/SRL read rs1 and rs2.
  - ADDI/LW read rs1.
  - SW reads rs1 and rs2.
  - NOP/illegal read none.
- Load enable: load = !ex_valid || ex_ready.
- hazard_stall = if_valid && ex_valid && ex_mem_read && ex_rd != 0 && the incoming instruction reads ex_rd on rs1 or rs2.
- if_ready = load && (!hazard_stall || flush).
- Per-cycle update, in priority order:
  1. flush: ex_valid <= 0; the offered instruction is accepted and dropped (if_ready = 1).
  2. load && hazard_stall: bubble (ex_valid <= 0); IF is held.
  3. load && if_valid: decoded instruction is registered; ex_valid <= 1.
  4. load && !if_valid: ex_valid <= 0.
  5. !load: all ex_* outputs hold stable.
- Latency: one cycle from the IF handshake to ex_valid.
- Throughput: one instruction per cycle without hazards. A load-use pair costs exactly one bubble.
- Reset: all ex_* outputs = 0, ex_valid = 0, and the optional counter = 0, taking effect immediately. Reset mid-operation drops the in-flight instruction. if_ready = 1 while in reset and on the first cycle after.
- Bubble cycles leave the ex_* payload don't-care. Downstream qualifies on ex_valid.

Optional Feature:
- Macro: DECODE_STALL_CNT_EN.
- When defined:
  - Adds output stall_count (32 bits).
  - Increments once per cycle where hazard_stall && load && !flush.
  - Saturates at all-ones; resets to 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package decode_pkg:
  - opcode localparams (OP_ADD..OP_NOP)
  - alu_op encodings
  - packed control struct (reg_write, alu_src, mem_write, mem_read, mem_to_reg, alu_op, illegal)
- Sub-module decode_ctrl: purely combinational opcode → control struct, plus a source-use mask (uses_rs1, uses_rs2).
- decode_stage holds the handshake, hazard compare, ID/EX register and optional counter.

Test Plan:
1. ADD rd=3, rs1=1, rs2=2, ex_ready=1 → next cycle ex_valid=1, reg_write=1, alu_op=00, alu_src=0, ex_rd=3, ex_rs1=1, ex_rs2=2.
2. ADDI rd=4, rs1=0, imm=0xFFF → ex_imm=0xFFFFFFFF, alu_src=1. ADD rd=0 → reg_write=0.
3. LW r5 followed by ADD r6, r5, r1 back-to-back:
   - one cycle with hazard_stall=1, if_ready=0, ex_valid=0 bubble;
   - ADD issues the following cycle;
   - stall_count=1 (macro on).
   - LW r0 followed by ADD r6, r0, r1 → no stall.
4. ex_ready=0 for 3 cycles with if_valid=1 → if_ready=0 and ex_* stable throughout; with ex_ready=1, the next instruction is accepted the same cycle.
5. flush asserted while ex_valid=1 and if_valid=1 → if_ready=1, next-cycle ex_valid=0, dropped instruction never appears. Same during a hazard stall → no bubble counted.
6. OP_W=4, opcode 9 → ex_valid=1, ex_illegal=1, all writes 0. rst_n low mid-stream → ex_valid=0 immediately (asynchronously), outputs 0.
